// File: rtl/condicionador_botoes.sv
// condicionador_botoes: synchronizes, debounces and validates single-button presses.
// Define CONDICIONADOR_SYNC2_EN for a two-flop synchronizer (S=2); otherwise S=1.
module condicionador_botoes #(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       zera,
    input  logic       habilita,
    input  logic [6:0] botoes_brutos,
    output logic [6:0] botoes,
    output logic       jogada,
    output logic       invalido,
    output logic [2:0] db_codigo,
    output logic [1:0] db_estado
);

    localparam int CW = $clog2(DEBOUNCE_CICLOS);
    // The cycle that enters FILTRANDO/SOLTANDO already counts as the first stable one
    localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS - 2);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        FILTRANDO   = 2'd1,
        PRESSIONADO = 2'd2,
        SOLTANDO    = 2'd3
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [6:0]    cand_q, cand_d;
    logic [6:0]    botoes_q, botoes_d;
    logic [2:0]    codigo_q, codigo_d;
    logic          jogada_q, jogada_d;
    logic          invalido_q, invalido_d;
    logic [6:0]    s;

`ifdef CONDICIONADOR_SYNC2_EN
    logic [6:0] meta_q, sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= botoes_brutos;
            sync_q <= meta_q;
        end
    end
`else
    logic [6:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= botoes_brutos;
        end
    end
`endif

    assign s = sync_q;

    function automatic logic [2:0] codifica(input logic [6:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < 7; i++) begin
            if (v[i]) c = 3'(i + 1);
        end
        return c;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            cnt_q      <= '0;
            cand_q     <= '0;
            botoes_q   <= '0;
            codigo_q   <= '0;
            jogada_q   <= 1'b0;
            invalido_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            botoes_q   <= botoes_d;
            codigo_q   <= codigo_d;
            jogada_q   <= jogada_d;
            invalido_q <= invalido_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        botoes_d   = botoes_q;
        codigo_d   = codigo_q;
        jogada_d   = 1'b0;
        invalido_d = 1'b0;
        cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        if (zera) begin
            estado_d = OCIOSO;
            cnt_d    = '0;
            cand_d   = '0;
            botoes_d = '0;
            codigo_d = '0;
        end else begin
            unique case (estado_q)
                OCIOSO: begin
                    if (s != '0) begin
                        estado_d = FILTRANDO;
                        cand_d   = s;
                        cnt_d    = '0;
                    end
                end
                FILTRANDO: begin
                    if (s == '0) begin
                        estado_d = OCIOSO;
                        cnt_d    = '0;
                    end else if (s != cand_q) begin
                        cand_d = s;
                        cnt_d  = '0;
                    end else if (cnt_q == CNT_FIM) begin
                        cnt_d = '0;
                        if (!$onehot(cand_q)) begin
                            invalido_d = 1'b1;
                            estado_d   = SOLTANDO;
                        end else begin
                            estado_d = PRESSIONADO;
                            if (habilita) begin
                                botoes_d = cand_q;
                                codigo_d = codifica(cand_q);
                                jogada_d = 1'b1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                PRESSIONADO: begin
                    if (s == '0) begin
                        estado_d = SOLTANDO;
                        cnt_d    = '0;
                    end
                end
                SOLTANDO: begin
                    if (s != '0) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_FIM) begin
                        estado_d = OCIOSO;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: estado_d = OCIOSO;
            endcase
        end
    end

    assign botoes    = botoes_q;
    assign jogada    = jogada_q;
    assign invalido  = invalido_q;
    assign db_codigo = codigo_q;
    assign db_estado = estado_q;

endmodule
